// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 Set-2 key controller.
package ps2_pkg;

   localparam logic [7:0] SC_E0         = 8'hE0;
   localparam logic [7:0] SC_F0         = 8'hF0;
   localparam logic [7:0] SC_E1         = 8'hE1;
   localparam logic [7:0] SC_AA         = 8'hAA;
   localparam logic [7:0] SC_FA         = 8'hFA;
   localparam logic [7:0] SC_FE         = 8'hFE;
   localparam logic [7:0] SC_FAKE_SHIFT = 8'h12;

   localparam logic [3:0] ADDR_DATA   = 4'h0;
   localparam logic [3:0] ADDR_STATUS = 4'h4;
   localparam logic [3:0] ADDR_CTRL   = 4'h8;

   // Bytes following E1 in the pause make sequence.
   localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

   typedef struct packed {
      logic       rel;
      logic       ext;
      logic [7:0] code;
   } key_event_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK,
      ST_PAUSE_SKIP
   } dec_state_e;

   // Self-test, ack, resend and error bytes never become events.
   function automatic logic is_ignored(input logic [7:0] b);
      return (b == SC_AA) || (b == SC_FA) || (b == SC_FE) ||
             (b == 8'h00) || (b == 8'hFF);
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous key-event FIFO with flush; a push into a full FIFO is dropped
// unless a pop frees a slot in the same cycle.
module ps2_event_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [9:0]               wdata,
   output logic [9:0]               rdata,
   output logic                     full,
   output logic                     empty,
   output logic                     drop,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   key_event_t        mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              do_push, do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & (~full | do_pop) & ~flush;
   assign drop    = push & full & ~do_pop & ~flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= key_event_t'(wdata);
   end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 Set-2 prefix decoder feeding an event FIFO, exposed as DATA/STATUS/CTRL
// registers with a level interrupt.
module ps2_key_ctrl
   import ps2_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic        clk_50_i,
   input  logic        rst_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [3:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        rvalid_o,
   output logic        irq_o
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   dec_state_e    state_q, state_d;
   logic [2:0]    skip_q, skip_d;
   logic [TW-1:0] idle_q, idle_d;
   logic          bv_q;
   logic          ovf_q, ovf_d;
   logic          irq_en_q, irq_en_d;
   logic          irq_q, irq_d;
   logic          rvalid_q, rvalid_d;
   logic [31:0]   rdata_q, rdata_d;

   logic          strobe, push, pop, flush, rd, ctrl_wr;
   key_event_t    ev;
   logic [9:0]    head;
   logic          full, empty, drop;
   logic [CW-1:0] count;
   logic          unused_wdata;

   assign strobe       = byte_valid_i & ~bv_q;
   assign unused_wdata = ^{wdata_i[31:3], full};

   always_comb begin
      state_d = state_q;
      skip_d  = skip_q;
      push    = 1'b0;
      ev      = '{rel: 1'b0, ext: 1'b0, code: byte_i};
      idle_d  = (state_q == ST_IDLE || strobe) ? '0 : idle_q + 1'b1;
      if (strobe) begin
         case (state_q)
            ST_IDLE: begin
               if (byte_i == SC_E0)      state_d = ST_EXT;
               else if (byte_i == SC_F0) state_d = ST_BRK;
               else if (byte_i == SC_E1) begin
                  state_d = ST_PAUSE_SKIP;
                  skip_d  = PAUSE_SKIP_LEN;
               end else push = ~is_ignored(byte_i);
            end
            ST_EXT: begin
               if (byte_i == SC_F0) state_d = ST_EXT_BRK;
               else begin
                  state_d = ST_IDLE;
                  push    = (byte_i != SC_FAKE_SHIFT);
                  ev.ext  = 1'b1;
               end
            end
            ST_BRK: begin
               state_d = ST_IDLE;
               push    = 1'b1;
               ev.rel  = 1'b1;
            end
            ST_EXT_BRK: begin
               state_d = ST_IDLE;
               push    = (byte_i != SC_FAKE_SHIFT);
               ev.rel  = 1'b1;
               ev.ext  = 1'b1;
            end
            ST_PAUSE_SKIP: begin
               skip_d = skip_q - 1'b1;
               // The whole 8-byte pause sequence collapses to one extended E1.
               if (skip_d == '0) begin
                  state_d = ST_IDLE;
                  push    = 1'b1;
                  ev      = '{rel: 1'b0, ext: 1'b1, code: SC_E1};
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE && idle_q == TMO_LAST) begin
         state_d = ST_IDLE;
      end
   end

   always_comb begin
      rd       = req_i & ~we_i;
      ctrl_wr  = req_i & we_i & (addr_i == ADDR_CTRL);
      pop      = rd & (addr_i == ADDR_DATA);
      flush    = ctrl_wr & wdata_i[2];
      rvalid_d = rd;
      rdata_d  = rdata_q;
      if (rd) begin
         case (addr_i)
            ADDR_DATA:   rdata_d = empty ? 32'h0 : {22'b0, head};
            ADDR_STATUS: rdata_d = {23'b0, 5'(count), 1'b0, irq_en_q, ovf_q, ~empty};
            ADDR_CTRL:   rdata_d = {31'b0, irq_en_q};
            default:     rdata_d = 32'h0;
         endcase
      end
      irq_en_d = ctrl_wr ? wdata_i[0] : irq_en_q;
      ovf_d    = ovf_q;
      if (ctrl_wr && wdata_i[1]) ovf_d = 1'b0;
      if (drop)                  ovf_d = 1'b1;
      irq_d = irq_en_q & ~empty;
   end

   ps2_event_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk_50_i),
      .rst_n (rst_i),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata (ev),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .drop  (drop),
      .count (count)
   );

   always_ff @(posedge clk_50_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= ST_IDLE;
         skip_q   <= '0;
         idle_q   <= '0;
         bv_q     <= 1'b0;
         ovf_q    <= 1'b0;
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         skip_q   <= skip_d;
         idle_q   <= idle_d;
         bv_q     <= byte_valid_i;
         ovf_q    <= ovf_d;
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;
   assign irq_o    = irq_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: table of byte sequences plus hand-written
// overflow, interrupt, timeout and reset sequences.
module tb_ps2_key_ctrl;
   import ps2_pkg::*;

   localparam int DEPTH = 8;
   localparam int TMO   = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bv = 1'b0;
   logic [7:0]  b = 8'h0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  addr = 4'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        rvalid;
   logic        irq;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ps2_key_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
      .clk_50_i     (clk),
      .rst_i        (rst_n),
      .byte_valid_i (bv),
      .byte_i       (b),
      .req_i        (req),
      .we_i         (we),
      .addr_i       (addr),
      .wdata_i      (wdata),
      .rdata_o      (rdata),
      .rvalid_o     (rvalid),
      .irq_o        (irq)
   );

   typedef struct {
      string            name;
      int               nb;
      logic [9:0][7:0]  seq;   // byte i at seq[9-i]
      int               ne;
      logic [1:0][9:0]  ev;    // event k at ev[1-k]
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] v);
      @(negedge clk); b = v; bv = 1'b1;
      repeat (5) @(negedge clk);
      bv = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk); req = 1'b1; we = 1'b0; addr = a;
      @(negedge clk); req = 1'b0;
      d = rdata;
      check("rvalid", {31'b0, rvalid}, 32'h1);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] v);
      @(negedge clk); req = 1'b1; we = 1'b1; addr = a; wdata = v;
      @(negedge clk); req = 1'b0; we = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic        got;

      vecs[0] = '{"make_break",  3, {8'h1C, 8'hF0, 8'h1C, 56'h0}, 2, {10'h01C, 10'h21C}};
      vecs[1] = '{"extended",    7, {8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h12, 24'h0},
                  2, {10'h175, 10'h375}};
      vecs[2] = '{"pause",       9, {8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77,
                  8'h1C, 8'h0}, 2, {10'h1E1, 10'h01C}};
      vecs[3] = '{"ignored",     8, {8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF, 8'hE0, 8'hF0, 8'h12,
                  16'h0}, 0, {10'h0, 10'h0}};
      vecs[4] = '{"prefix_code", 4, {8'hF0, 8'hE0, 8'hE0, 8'hE0, 48'h0}, 2, {10'h2E0, 10'h1E0}};

      repeat (3) @(negedge clk);
      check("reset rdata", rdata, 32'h0);
      check("reset rvalid", {31'b0, rvalid}, 32'h0);
      check("reset irq", {31'b0, irq}, 32'h0);
      rst_n = 1'b1;
      rd(ADDR_STATUS, d); check("reset status", d, 32'h0);

      foreach (vecs[v]) begin
         for (int i = 0; i < vecs[v].nb; i++) send(vecs[v].seq[9-i]);
         rd(ADDR_STATUS, d);
         check({vecs[v].name, " status"}, d,
               32'((vecs[v].ne << 4) | ((vecs[v].ne > 0) ? 1 : 0)));
         for (int k = 0; k < vecs[v].ne; k++) begin
            rd(ADDR_DATA, d);
            check({vecs[v].name, " data"}, d, {22'b0, vecs[v].ev[1-k]});
         end
         rd(ADDR_STATUS, d);
         check({vecs[v].name, " drained"}, d, 32'h0);
      end

      // Writes to DATA/STATUS are ignored.
      send(8'h1C);
      wr(ADDR_DATA, 32'hFFFF_FFFF);
      wr(ADDR_STATUS, 32'hFFFF_FFFF);
      rd(ADDR_STATUS, d); check("ro status", d, 32'h011);
      rd(ADDR_DATA, d);   check("ro data", d, 32'h01C);

      // Overflow: nine presses into eight slots.
      for (int i = 0; i < 9; i++) send(8'(8'h15 + i));
      rd(ADDR_STATUS, d); check("ovf status", d, 32'h083);
      wr(ADDR_CTRL, 32'h2);
      rd(ADDR_STATUS, d); check("ovf cleared", d, 32'h081);
      rd(ADDR_DATA, d);   check("ovf head", d, 32'h015);
      wr(ADDR_CTRL, 32'h4);
      rd(ADDR_STATUS, d); check("flushed", d, 32'h0);

      // Interrupt.
      wr(ADDR_CTRL, 32'h1);
      rd(ADDR_CTRL, d);   check("ctrl read", d, 32'h1);
      rd(4'hC, d);        check("unmapped read", d, 32'h0);
      check("irq idle", {31'b0, irq}, 32'h0);
      @(negedge clk); b = 8'h1C; bv = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 3 && !got; c++) begin
         @(negedge clk);
         if (irq) got = 1'b1;
      end
      check("irq rise", {31'b0, got}, 32'h1);
      repeat (4) @(negedge clk);
      bv = 1'b0;
      @(negedge clk);
      rd(ADDR_DATA, d);   check("irq data", d, 32'h01C);
      @(negedge clk);
      check("irq fall", {31'b0, irq}, 32'h0);
      check("rvalid low", {31'b0, rvalid}, 32'h0);
      rd(ADDR_DATA, d);   check("empty read", d, 32'h0);
      rd(ADDR_STATUS, d); check("empty status", d, 32'h004);
      wr(ADDR_CTRL, 32'h0);

      // Prefix survives a gap shorter than the timeout.
      send(8'hF0);
      repeat (TMO / 2) @(negedge clk);
      send(8'h1C);
      rd(ADDR_DATA, d);   check("no timeout", d, 32'h21C);

      // Prefix abandoned after the timeout.
      send(8'hF0);
      repeat (TMO + 10) @(negedge clk);
      send(8'h1C);
      rd(ADDR_DATA, d);   check("timeout", d, 32'h01C);

      // Reset mid-prefix.
      send(8'hE0);
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk);
      check("midreset rdata", rdata, 32'h0);
      rst_n = 1'b1;
      send(8'h75);
      rd(ADDR_DATA, d);   check("midreset data", d, 32'h075);
      rd(ADDR_STATUS, d); check("midreset status", d, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
